// File: rtl/vote_pkg.sv
// Shared voter-count constants and FSM state type for the ballot collection path.

package vote_pkg;

    localparam int unsigned N_VOTERS = 6;
    localparam int unsigned ID_W     = 3;

    localparam logic [N_VOTERS-1:0] ALL_CAST = {N_VOTERS{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/ballot_timer.sv
// Saturating session timer; expires when the count reaches TIMEOUT_CYCLES-1.

module ballot_timer #(
    parameter int unsigned CNT_W          = 7,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire_c = (r_count == EXPIRE_AT);

endmodule

// File: rtl/ballot_collector.sv
// Collects one ballot per voter per session and presents the latched vote/weight
// vectors to the downstream weighted-majority stage until acknowledged.

module ballot_collector
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                ballot_valid,
    input  logic [ID_W-1:0]     ballot_id,
    input  logic                ballot_vote,
    input  logic                ballot_double,
    output logic                ballot_ready,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_VOTERS-1:0] inputs,
    output logic [N_VOTERS-1:0] doubles,
    output logic [N_VOTERS-1:0] cast_mask,
    output logic                timed_out,
    output logic                dup_err
);

    state_t              r_state,      w_state_nxt;
    logic [N_VOTERS-1:0] r_inputs,     w_inputs_nxt;
    logic [N_VOTERS-1:0] r_doubles,    w_doubles_nxt;
    logic [N_VOTERS-1:0] r_cast_mask,  w_cast_mask_nxt;
    logic                r_timed_out,  w_timed_out_nxt;
    logic                r_dup_err,    w_dup_err_nxt;
    logic                r_ballot_ready;
    logic                r_busy;
    logic                r_out_valid;

    logic [N_VOTERS-1:0] w_id_onehot;
    logic                w_fresh;
    logic                w_accept;
    logic                w_timer_clear;
    logic                w_timer_en;
    logic                w_expire_c;

    assign w_accept      = ballot_valid & r_ballot_ready;
    assign w_timer_clear = (r_state == IDLE) && start;
    assign w_timer_en    = (r_state == COLLECT);

    ballot_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clear),
        .i_enable   (w_timer_en),
        .o_expire_c (w_expire_c)
    );

    // Out-of-range ids decode to an all-zero one-hot and therefore never count as fresh.
    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            w_id_onehot[i] = (ballot_id == ID_W'(i));
        end
    end

    assign w_fresh = |(w_id_onehot & ~r_cast_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_inputs       <= '0;
            r_doubles      <= '0;
            r_cast_mask    <= '0;
            r_timed_out    <= 1'b0;
            r_dup_err      <= 1'b0;
            r_ballot_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_inputs       <= w_inputs_nxt;
            r_doubles      <= w_doubles_nxt;
            r_cast_mask    <= w_cast_mask_nxt;
            r_timed_out    <= w_timed_out_nxt;
            r_dup_err      <= w_dup_err_nxt;
            r_ballot_ready <= (w_state_nxt == COLLECT);
            r_busy         <= (w_state_nxt != IDLE);
            r_out_valid    <= (w_state_nxt == PRESENT);
        end
    end

    // Next state and ballot register updates; a ballot on the timeout cycle still counts.
    always_comb begin
        w_state_nxt     = r_state;
        w_inputs_nxt    = r_inputs;
        w_doubles_nxt   = r_doubles;
        w_cast_mask_nxt = r_cast_mask;
        w_timed_out_nxt = r_timed_out;
        w_dup_err_nxt   = r_dup_err;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = COLLECT;
                    w_inputs_nxt    = '0;
                    w_doubles_nxt   = '0;
                    w_cast_mask_nxt = '0;
                    w_timed_out_nxt = 1'b0;
                    w_dup_err_nxt   = 1'b0;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (w_fresh) begin
                        w_cast_mask_nxt = r_cast_mask | w_id_onehot;
                        w_inputs_nxt    = (r_inputs & ~w_id_onehot)
                                        | (w_id_onehot & {N_VOTERS{ballot_vote}});
                        w_doubles_nxt   = (r_doubles & ~w_id_onehot)
                                        | (w_id_onehot & {N_VOTERS{ballot_double}});
                    end else begin
                        w_dup_err_nxt = 1'b1;
                    end
                end
                if ((w_cast_mask_nxt == ALL_CAST) || w_expire_c) begin
                    w_state_nxt     = PRESENT;
                    w_timed_out_nxt = (w_cast_mask_nxt != ALL_CAST);
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ballot_ready = r_ballot_ready;
    assign busy         = r_busy;
    assign out_valid    = r_out_valid;
    assign inputs       = r_inputs;
    assign doubles      = r_doubles;
    assign cast_mask    = r_cast_mask;
    assign timed_out    = r_timed_out;
    assign dup_err      = r_dup_err;

endmodule

// File: tb/tb_ballot_collector.sv
// Randomized and directed sessions for ballot_collector against a per-session
// ballot-list reference model.

module tb_ballot_collector;
    import vote_pkg::*;

    localparam int unsigned TO = 64;
    localparam int unsigned CW = 7;
    localparam int unsigned SL = TO + 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                ballot_valid = 1'b0;
    logic [ID_W-1:0]     ballot_id = '0;
    logic                ballot_vote = 1'b0;
    logic                ballot_double = 1'b0;
    logic                out_ready = 1'b0;
    logic                ballot_ready, busy, out_valid, timed_out, dup_err;
    logic [N_VOTERS-1:0] inputs, doubles, cast_mask;

    int n_err = 0;
    int n_chk = 0;

    // Per-cycle stimulus for one session, indexed by cycles since ballot_ready rose.
    bit st_v  [SL];
    int st_id [SL];
    bit st_vo [SL];
    bit st_db [SL];

    // Reference model results for the current session.
    logic [N_VOTERS-1:0] m_in, m_db, m_cast;
    bit                  m_dup, m_to;
    int                  m_end;

    always #5 clk = ~clk;

    ballot_collector #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ballot_valid  (ballot_valid),
        .ballot_id     (ballot_id),
        .ballot_vote   (ballot_vote),
        .ballot_double (ballot_double),
        .ballot_ready  (ballot_ready),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inputs        (inputs),
        .doubles       (doubles),
        .cast_mask     (cast_mask),
        .timed_out     (timed_out),
        .dup_err       (dup_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream weighted majority: yes weight must exceed half the total weight.
    function automatic bit weighted_majority(input logic [N_VOTERS-1:0] v, input logic [N_VOTERS-1:0] d);
        int yes = 0;
        int tot = 0;
        for (int i = 0; i < N_VOTERS; i++) begin
            tot += 1 + int'(d[i]);
            if (v[i]) yes += 1 + int'(d[i]);
        end
        return (2 * yes) > tot;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < SL; i++) begin
            st_v[i] = 1'b0; st_id[i] = 0; st_vo[i] = 1'b0; st_db[i] = 1'b0;
        end
    endtask

    task automatic set_ballot(input int k, input int id, input bit vo, input bit db);
        st_v[k] = 1'b1; st_id[k] = id; st_vo[k] = vo; st_db[k] = db;
    endtask

    task automatic fill_random(input int pct);
        for (int i = 0; i < SL; i++) begin
            st_v[i]  = ($urandom_range(0, 99) < pct);
            st_id[i] = $urandom_range(0, 7);
            st_vo[i] = 1'($urandom_range(0, 1));
            st_db[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic open_session(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".ready_rise"}, 32'(ballot_ready), 32'd1);
        check({tag, ".busy"},       32'(busy),         32'd1);
        check({tag, ".mask_clear"}, 32'(cast_mask),    32'd0);
        check({tag, ".flags_clear"}, 32'({timed_out, dup_err, out_valid}), 32'd0);
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".inputs"},    32'(inputs),    32'(m_in));
        check({tag, ".doubles"},   32'(doubles),   32'(m_db));
        check({tag, ".cast_mask"}, 32'(cast_mask), 32'(m_cast));
        check({tag, ".timed_out"}, 32'(timed_out), 32'(m_to));
        check({tag, ".dup_err"},   32'(dup_err),   32'(m_dup));
    endtask

    // Drives the stimulus table, steps the model and waits (bounded) for out_valid.
    task automatic collect(input string tag);
        int obs_end = -1;
        m_in = '0; m_db = '0; m_cast = '0; m_dup = 1'b0; m_to = 1'b0; m_end = -1;
        for (int k = 0; k < SL; k++) begin
            if (m_end < 0 && st_v[k]) begin
                ballot_valid  = 1'b1;
                ballot_id     = ID_W'(st_id[k]);
                ballot_vote   = st_vo[k];
                ballot_double = st_db[k];
            end else begin
                ballot_valid  = 1'($urandom_range(0, 1)) & (m_end >= 0);
                ballot_id     = ID_W'($urandom_range(0, 7));
            end
            if (m_end < 0) begin
                if (st_v[k]) begin
                    if (st_id[k] < N_VOTERS && !m_cast[st_id[k]]) begin
                        m_cast[st_id[k]] = 1'b1;
                        m_in[st_id[k]]   = st_vo[k];
                        m_db[st_id[k]]   = st_db[k];
                    end else begin
                        m_dup = 1'b1;
                    end
                end
                if (m_cast == ALL_CAST || k == TO - 1) begin
                    m_end = k;
                    m_to  = (m_cast != ALL_CAST);
                end
            end
            tick();
            ballot_valid = 1'b0;
            if (out_valid) begin
                obs_end = k;
                break;
            end
        end
        check({tag, ".end_cycle"}, 32'(obs_end), 32'(m_end));
        check({tag, ".ready_low"}, 32'(ballot_ready), 32'd0);
        check_fields(tag);
    endtask

    // Holds out_ready low (optionally poking start), then completes the handshake.
    task automatic close_session(input string tag, input int hold, input bit poke_start);
        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            start = poke_start;
            tick();
            check({tag, ".hold_valid"}, 32'({out_valid, busy, ballot_ready}), 32'b110);
            check({tag, ".hold_cast"},  32'(cast_mask), 32'(m_cast));
            check({tag, ".hold_in"},    32'({inputs, doubles}), 32'({m_in, m_db}));
        end
        out_ready = 1'b1;
        start     = poke_start;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, ".ack_idle"}, 32'({out_valid, busy, ballot_ready}), 32'b000);
        check_fields({tag, ".after_ack"});
        tick();
        check({tag, ".stay_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset.ctrl", 32'({ballot_ready, busy, out_valid, timed_out, dup_err}), 32'd0);
        check("reset.vec",  32'({inputs, doubles, cast_mask}), 32'd0);

        // Full session, one ballot per cycle, 10 cycles of backpressure.
        clear_stim();
        set_ballot(0, 0, 1'b1, 1'b1);
        set_ballot(1, 1, 1'b1, 1'b0);
        set_ballot(2, 2, 1'b0, 1'b0);
        set_ballot(3, 3, 1'b0, 1'b0);
        set_ballot(4, 4, 1'b1, 1'b0);
        set_ballot(5, 5, 1'b0, 1'b0);
        open_session("full");
        collect("full");
        check("full.inputs_const", 32'(inputs), 32'b010011);
        check("full.end_const",    32'(m_end),  32'd5);
        check("full.majority", 32'(weighted_majority(inputs, doubles)), 32'd1);
        close_session("full", 10, 1'b1);

        // Timeout with only two voters.
        clear_stim();
        set_ballot(0, 1, 1'b1, 1'b0);
        set_ballot(7, 3, 1'b1, 1'b0);
        open_session("tmo");
        collect("tmo");
        check("tmo.cast_const", 32'(cast_mask), 32'b001010);
        check("tmo.to_const",   32'(timed_out), 32'd1);
        close_session("tmo", 2, 1'b0);

        // Duplicate and out-of-range ids.
        clear_stim();
        set_ballot(0, 2, 1'b1, 1'b0);
        set_ballot(1, 2, 1'b0, 1'b1);
        set_ballot(2, 7, 1'b1, 1'b1);
        open_session("dup");
        collect("dup");
        check("dup.in2",  32'(inputs[2]), 32'd1);
        check("dup.flag", 32'(dup_err),   32'd1);
        close_session("dup", 1, 1'b1);

        // Last missing ballot lands on the timeout cycle.
        clear_stim();
        for (int i = 0; i < 5; i++) set_ballot(i, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        set_ballot(TO - 1, 5, 1'b1, 1'b1);
        open_session("edge");
        collect("edge");
        check("edge.cast_const", 32'(cast_mask), 32'b111111);
        check("edge.to_const",   32'(timed_out), 32'd0);
        close_session("edge", 0, 1'b0);

        // Randomized sessions: dense traffic and sparse traffic that tends to time out.
        for (int s = 0; s < 12; s++) begin
            fill_random((s % 3 == 2) ? 3 : 45);
            open_session("rand");
            collect("rand");
            close_session("rand", $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Reset mid-collect after three ballots.
        clear_stim();
        for (int i = 0; i < 3; i++) set_ballot(i, i, 1'b1, 1'b1);
        open_session("rst");
        for (int k = 0; k < 3; k++) begin
            ballot_valid = 1'b1; ballot_id = ID_W'(k); ballot_vote = 1'b1; ballot_double = 1'b1;
            tick();
        end
        ballot_valid = 1'b0;
        check("rst.pre_mask", 32'(cast_mask), 32'b000111);
        #2 rst_n = 1'b0;
        #1;
        check("rst.ctrl", 32'({ballot_ready, busy, out_valid, timed_out, dup_err}), 32'd0);
        check("rst.vec",  32'({inputs, doubles, cast_mask}), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        fill_random(45);
        open_session("post_rst");
        collect("post_rst");
        close_session("post_rst", 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
